bcd_digit_converter: RTL
========================

# bcd_digit_converter

Sequential binary-to-digit converter between the 12-bit counter core and the four seven-segment decoders. It turns the counter value into four 4-bit digits in the selected number system: decimal BCD via 12-step double-dabble, or hexadecimal via direct nibble split. It also produces a leading-zero blank mask. The result is presented with a start/busy/done handshake so the core can request refreshes at its own rate.

## Interface
- P_WIDTH, 12, binary input width; fixed at 12 for this design, and the bench checks only 12.
- P_DIGITS, 4, number of output digits.
- i_clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- i_value  in  12  unsigned binary value to convert; sampled only when a start is accepted.
- i_nsyst  in  1  number system select, sampled with i_value: 1 = decimal BCD, 0 = hexadecimal.
- i_start  in  1  conversion request, level-sampled at each rising edge.
- o_busy  out  1  high while a conversion is in progress (state not IDLE).
- o_done  out  1  one-cycle pulse; o_digits and o_blank were updated at the same edge.
- o_digits  out  16  digit d in [4d+3:4d]; digit 0 is least significant; registered.
- o_blank  out  4  bit d = 1: digit d is a leading zero and must be blanked. Bit 0 is always 0.

## Operation
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - o_digits = 16'h0000, o_blank = 4'b1110 (display shows a single "0"), o_busy = 0, o_done = 0.
  - Scratch registers are cleared and any in-flight conversion is abandoned with no o_done.
- State IDLE:
  - i_start = 1 at an edge is accepted: i_value and i_nsyst are latched into scratch.
  - Decimal: BCD accumulator = 0, shift counter = 12, next state SHIFT.
  - Hex: scratch digits = i_value split into nibbles, digit 3 = 0, next state DONE.
- State SHIFT, one double-dabble iteration per edge:
  - Each scratch BCD digit >= 5 gets +3 (4-bit add, no carry-out).
  - Then {bcd, bin} shifts left by 1 and the counter decrements.
  - The edge that performs the 12th shift moves the state to DONE.
- State DONE, one edge:
  - o_digits <= scratch digits.
  - o_blank <= leading-zero mask: digit d is blanked iff it and all higher digits are zero, for d >= 1.
  - o_done <= 1, next state IDLE.
- o_done is 1 for exactly one cycle and 0 at every other time.
- o_digits and o_blank hold their last values between conversions.
- i_start while o_busy = 1 (SHIFT or DONE) is ignored. It is not queued and the latched operands do not change.
- i_value and i_nsyst changing mid-conversion has no effect.
- Maximum decimal input 4095 yields 4,0,9,5; no overflow is possible. Hex digit 3 is always 0.
- Internal zeros are never blanked: 0x105 hex gives blank 4'b1000.

## Timing
- Start sampled at edge k; o_busy = 1 from edge k.
- Decimal:
  - Shifts happen at edges k+1 … k+12; state is DONE after edge k+12.
  - At edge k+13: outputs update, o_done = 1, o_busy = 0. o_done falls at edge k+14.
  - Latency is 13 cycles.
- Hex:
  - At edge k+1: outputs update, o_done = 1, o_busy = 0.
  - Latency is 1 cycle.
- Back-to-back: a new start is accepted at the edge ending the o_done cycle (state IDLE). Maximum decimal throughput is one result per 14 cycles.
- Reset asserted at any point returns all outputs to reset values immediately, without waiting for a clock. The first start is accepted at the first edge after reset deasserts.

## Test plan
- i_value = 12'hB78, i_nsyst = 1, one-cycle start:
  - o_done exactly 13 cycles later.
  - o_digits = 16'h2936, o_blank = 4'b0000.
  - o_busy high for 13 cycles.
- Same value, i_nsyst = 0 -> o_done 1 cycle later, o_digits = 16'h0B78, o_blank = 4'b1000.
- Decimal corner values:
  - 0 -> o_digits 16'h0000, o_blank 4'b1110.
  - 7 -> 16'h0007, 4'b1110.
  - 105 -> 16'h0105, 4'b1000.
  - 4095 -> 16'h4095, 4'b0000.
- Start decimal 2936; at cycle 5 pulse i_start again with i_value = 1:
  - Result is 16'h2936 with a single o_done.
  - A new start on the o_done cycle is accepted and yields 16'h0001 after 13 more cycles.
- Start decimal 2936; assert reset at cycle 6:
  - Outputs immediately go to 16'h0000, 4'b1110, busy 0, done 0.
  - No o_done follows.
  - After release, a start with 4095 yields 16'h4095 after 13 cycles.
- Hold i_start = 1 continuously in decimal mode -> o_done every 14 cycles, digits always consistent with the value sampled at each accept.

Source files
------------

// File: rtl/bcd_digit_converter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_converter
// Brief    : Sequential 12-bit binary to four-digit converter (double-dabble
//            BCD or hex nibble split) with leading-zero blank mask.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_converter #(
    parameter int P_WIDTH  = 12,
    parameter int P_DIGITS = 4
) (
    input  logic                    i_clk,
    input  logic                    reset,
    input  logic [P_WIDTH-1:0]      i_value,
    input  logic                    i_nsyst,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*P_DIGITS-1:0]   o_digits,
    output logic [P_DIGITS-1:0]     o_blank
);

    localparam int c_BCD_W = 4 * P_DIGITS;
    localparam int c_CNT_W = $clog2(P_WIDTH + 1);
    localparam int c_PAD_W = c_BCD_W - P_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [P_WIDTH-1:0]          r_bin;
    logic [c_BCD_W-1:0]          r_bcd;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [c_BCD_W-1:0]          w_adj;
    logic [c_BCD_W+P_WIDTH-1:0]  w_shifted;
    logic [P_DIGITS-1:0]         w_blank;

    generate
        for (genvar g = 0; g < P_DIGITS; g++) begin : g_adj
            assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                               : r_bcd[4*g +: 4];
        end
    endgenerate

    assign w_shifted = {w_adj, r_bin} << 1;

    // A digit is blanked only when it and every digit above it are zero.
    assign w_blank[0] = 1'b0;
    generate
        for (genvar g = 1; g < P_DIGITS; g++) begin : g_blank
            assign w_blank[g] = (r_bcd[c_BCD_W-1:4*g] == '0);
        end
    endgenerate

    assign o_busy = (r_state != S_IDLE);

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = i_nsyst ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_cnt == c_CNT_W'(1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            o_done   <= 1'b0;
            o_digits <= '0;
            o_blank  <= {{(P_DIGITS-1){1'b1}}, 1'b0};
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_bin <= i_value;
                        if (i_nsyst) begin
                            r_bcd <= '0;
                            r_cnt <= c_CNT_W'(P_WIDTH);
                        end else begin
                            r_bcd <= {{c_PAD_W{1'b0}}, i_value};
                            r_cnt <= '0;
                        end
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_shifted[c_BCD_W+P_WIDTH-1 -: c_BCD_W];
                    r_bin <= w_shifted[P_WIDTH-1:0];
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                S_DONE: begin
                    o_digits <= r_bcd;
                    o_blank  <= w_blank;
                    o_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
